// File: rtl/dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dispense_sequencer
// Description : Runs one candy-dispense cycle per Pi request. It spins up
//               the DC agitator, emits an exact number of stepper pulses
//               chosen by a 2-bit amount code, lets the mechanism settle,
//               and then raises a handshake back to the Pi.
//               Optional macro DISPENSE_HS_TIMEOUT_EN enables a handshake
//               timeout in DONE that returns to IDLE and pulses fault.
// Revision    : 1.0 - initial release
// ============================================================================
module dispense_sequencer #(
    parameter int STEP_HALF  = 2000,
    parameter int SPINUP_CYC = 20000,
    parameter int SETTLE_CYC = 20000,
    parameter int STEPS_A0   = 100,
    parameter int STEPS_A1   = 200,
    parameter int STEPS_A2   = 300,
    parameter int STEPS_A3   = 100,
    parameter int CNT_W      = 16,
    parameter int HS_TIMEOUT = 200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_req,
    input  logic [1:0]       cmd_amount,
    output logic             step_out,
    output logic             step_dir,
    output logic             dc_en,
    output logic [1:0]       dc_dir,
    output logic             busy,
    output logic             handshake,
    output logic [CNT_W-1:0] steps_done,
    output logic             fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPINUP  = 3'd1,
        S_STEP_HI = 3'd2,
        S_STEP_LO = 3'd3,
        S_SETTLE  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_SPIN_LAST   = CNT_W'(SPINUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST   = CNT_W'(STEP_HALF - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [1:0]       c_DIR_RUN     = 2'b10;

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [1:0]       r_amt;
    logic             r_sync1;
    logic             r_req_s;
    logic             r_req_d;
    logic [1:0]       r_vld;
    logic             r_armed;

    logic [CNT_W-1:0] w_target;
    logic [CNT_W-1:0] w_steps_inc;
    logic             w_start;

`ifdef DISPENSE_HS_TIMEOUT_EN
    localparam int               c_TO_W    = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(HS_TIMEOUT - 1);
    logic [c_TO_W-1:0] r_to_cnt;
`else
    assign fault = 1'b0;
`endif

    assign step_dir = 1'b0;

    // Target pulse count follows the amount code latched at the start edge
    always_comb begin
        w_target = CNT_W'(STEPS_A0);
        case (r_amt)
            2'b00:   w_target = CNT_W'(STEPS_A0);
            2'b01:   w_target = CNT_W'(STEPS_A1);
            2'b10:   w_target = CNT_W'(STEPS_A2);
            default: w_target = CNT_W'(STEPS_A3);
        endcase
    end

    assign w_steps_inc = steps_done + CNT_W'(1);
    // A start needs a real rising edge; a level already high out of reset
    // never arms the detector until it has been seen low.
    assign w_start     = r_req_s & ~r_req_d & r_armed;

    // Request synchronizer, edge-detect delay and re-arm tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_req_s <= 1'b0;
            r_req_d <= 1'b0;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= cmd_req;
            r_req_s <= r_sync1;
            r_req_d <= r_req_s;
            // r_vld[1] marks that r_req_s now holds a genuine post-reset sample
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && !r_req_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Dispense sequence FSM with registered motor and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_amt      <= 2'b00;
            step_out   <= 1'b0;
            dc_en      <= 1'b0;
            dc_dir     <= 2'b00;
            busy       <= 1'b0;
            handshake  <= 1'b0;
            steps_done <= '0;
`ifdef DISPENSE_HS_TIMEOUT_EN
            r_to_cnt   <= '0;
            fault      <= 1'b0;
`endif
        end else begin
`ifdef DISPENSE_HS_TIMEOUT_EN
            fault <= 1'b0;
`endif
            if ((r_state == S_SPINUP || r_state == S_STEP_HI ||
                 r_state == S_STEP_LO || r_state == S_SETTLE) && !r_req_s) begin
                // Request withdrawn mid-run: stop motors, keep partial count
                r_state  <= S_IDLE;
                r_timer  <= '0;
                step_out <= 1'b0;
                dc_en    <= 1'b0;
                dc_dir   <= 2'b00;
                busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_amt      <= cmd_amount;
                            steps_done <= '0;
                            r_timer    <= '0;
                            r_state    <= S_SPINUP;
                            dc_en      <= 1'b1;
                            dc_dir     <= c_DIR_RUN;
                            busy       <= 1'b1;
                        end
                    end
                    S_SPINUP: begin
                        if (r_timer == c_SPIN_LAST) begin
                            r_timer <= '0;
                            if (w_target == '0) begin
                                r_state <= S_SETTLE;
                            end else begin
                                r_state  <= S_STEP_HI;
                                step_out <= 1'b1;
                            end
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                    S_STEP_HI: begin
                        if (r_timer == c_HALF_LAST) begin
                            r_timer  <= '0;
                            r_state  <= S_STEP_LO;
                            step_out <= 1'b0;
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                    S_STEP_LO: begin
                        if (r_timer == c_HALF_LAST) begin
                            r_timer    <= '0;
                            steps_done <= w_steps_inc;
                            if (w_steps_inc == w_target) begin
                                r_state <= S_SETTLE;
                            end else begin
                                r_state  <= S_STEP_HI;
                                step_out <= 1'b1;
                            end
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (r_timer == c_SETTLE_LAST) begin
                            r_timer   <= '0;
                            r_state   <= S_DONE;
                            dc_en     <= 1'b0;
                            dc_dir    <= 2'b00;
                            handshake <= 1'b1;
`ifdef DISPENSE_HS_TIMEOUT_EN
                            r_to_cnt  <= '0;
`endif
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (!r_req_s) begin
                            handshake <= 1'b0;
                            busy      <= 1'b0;
                            r_state   <= S_IDLE;
`ifdef DISPENSE_HS_TIMEOUT_EN
                        end else if (r_to_cnt == c_TO_LAST) begin
                            // Pi never acknowledged: give up and flag it once
                            fault     <= 1'b1;
                            handshake <= 1'b0;
                            busy      <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_W'(1);
`endif
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispense_sequencer
// Description : Directed self-checking bench for dispense_sequencer using
//               short timing parameters and hand-derived waveforms.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispense_sequencer;

    localparam int P_HALF   = 2;
    localparam int P_SPIN   = 8;
    localparam int P_SETTLE = 4;
    localparam int P_A0     = 5;
    localparam int P_A1     = 3;
    localparam int P_A2     = 4;
    localparam int P_A3     = 0;
    localparam int P_CNT_W  = 16;
    localparam int P_HS_TO  = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_req;
    logic [1:0]         cmd_amount;
    logic               step_out;
    logic               step_dir;
    logic               dc_en;
    logic [1:0]         dc_dir;
    logic               busy;
    logic               handshake;
    logic [P_CNT_W-1:0] steps_done;
    logic               fault;

    int checks = 0;
    int errors = 0;

    dispense_sequencer #(
        .STEP_HALF  (P_HALF),
        .SPINUP_CYC (P_SPIN),
        .SETTLE_CYC (P_SETTLE),
        .STEPS_A0   (P_A0),
        .STEPS_A1   (P_A1),
        .STEPS_A2   (P_A2),
        .STEPS_A3   (P_A3),
        .CNT_W      (P_CNT_W),
        .HS_TIMEOUT (P_HS_TO)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_req    (cmd_req),
        .cmd_amount (cmd_amount),
        .step_out   (step_out),
        .step_dir   (step_dir),
        .dc_en      (dc_en),
        .dc_dir     (dc_dir),
        .busy       (busy),
        .handshake  (handshake),
        .steps_done (steps_done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Expected waveform, index 0 = first cycle with dc_en high
    function automatic logic exp_step(input int i, input int n);
        if (i < P_SPIN || i >= P_SPIN + 2*P_HALF*n) return 1'b0;
        return (((i - P_SPIN) % (2*P_HALF)) < P_HALF);
    endfunction

    function automatic logic exp_dc(input int i, input int n);
        return (i < P_SPIN + 2*P_HALF*n + P_SETTLE);
    endfunction

    task automatic drop_req();
        cmd_req = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_req = 1'b0; cmd_amount = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({step_out, step_dir, dc_en, dc_dir, busy, handshake, fault} !== 8'b0 ||
            steps_done !== '0) begin
            errors++;
            $display("FAIL reset_outputs step=%b dir=%b dc=%b dcdir=%b busy=%b hs=%b fault=%b steps=%0d, expected all 0",
                     step_out, step_dir, dc_en, dc_dir, busy, handshake, fault, steps_done);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dc_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b dc_en=%b, expected 0 0", busy, dc_en);
        end
    endtask

    // Full dispense run; leaves the DUT in DONE with cmd_req high
    task automatic test_dispense_run(input logic [1:0] amt, input int n, input string tag);
        int len, e_st, e_dc, e_hs, e_bz, e_dir, pulses;
        logic prev;
        len = P_SPIN + 2*P_HALF*n + P_SETTLE + 2;
        e_st = 0; e_dc = 0; e_hs = 0; e_bz = 0; e_dir = 0; pulses = 0; prev = 1'b0;
        cmd_amount = amt;
        cmd_req    = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (dc_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_start_early dc_en=%b busy=%b after 2 edges, expected 0 0", tag, dc_en, busy);
        end
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (step_out !== exp_step(i, n)) e_st++;
            if (dc_en !== exp_dc(i, n)) e_dc++;
            if (dc_dir !== (exp_dc(i, n) ? 2'b10 : 2'b00)) e_dc++;
            if (handshake !== !exp_dc(i, n)) e_hs++;
            if (busy !== 1'b1) e_bz++;
            if (step_dir !== 1'b0 || fault !== 1'b0) e_dir++;
            if (step_out === 1'b1 && prev === 1'b0) pulses++;
            prev = step_out;
        end
        checks++;
        if (e_st != 0) begin
            errors++;
            $display("FAIL %s_step_wave %0d cycles wrong, expected 0", tag, e_st);
        end
        checks++;
        if (e_dc != 0) begin
            errors++;
            $display("FAIL %s_dc_wave %0d cycles wrong, expected 0", tag, e_dc);
        end
        checks++;
        if (e_hs != 0 || e_bz != 0 || e_dir != 0) begin
            errors++;
            $display("FAIL %s_hs_busy hs_err=%0d busy_err=%0d dir_fault_err=%0d, expected 0", tag, e_hs, e_bz, e_dir);
        end
        checks++;
        if (pulses != n || steps_done !== P_CNT_W'(n)) begin
            errors++;
            $display("FAIL %s_count pulses=%0d steps_done=%0d, expected %0d", tag, pulses, steps_done, n);
        end
    endtask

    task automatic test_release();
        cmd_req = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (handshake !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL release_early hs=%b busy=%b, expected 1 1", handshake, busy);
        end
        @(negedge clk);
        checks++;
        if (handshake !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_3edges hs=%b busy=%b, expected 0 0", handshake, busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int hs_hi;
        hs_hi = 0;
        cmd_amount = 2'b01;
        cmd_req    = 1'b1;
        repeat (3) @(negedge clk);
        // index 0 now; drop the request at index 14 (second pulse low phase)
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (handshake !== 1'b0) hs_hi++;
        end
        cmd_req = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (dc_en !== 1'b1 || steps_done !== P_CNT_W'(2)) begin
            errors++;
            $display("FAIL abort_before dc_en=%b steps=%0d, expected 1 2", dc_en, steps_done);
        end
        @(negedge clk);
        checks++;
        if (step_out !== 1'b0 || dc_en !== 1'b0 || dc_dir !== 2'b00 || busy !== 1'b0 ||
            steps_done !== P_CNT_W'(2)) begin
            errors++;
            $display("FAIL abort_stop step=%b dc=%b dcdir=%b busy=%b steps=%0d, expected 0 0 0 0 2",
                     step_out, dc_en, dc_dir, busy, steps_done);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (handshake !== 1'b0 || dc_en !== 1'b0) hs_hi++;
        end
        checks++;
        if (hs_hi != 0) begin
            errors++;
            $display("FAIL abort_no_handshake %0d bad cycles, expected 0", hs_hi);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        cmd_amount = 2'b01;
        cmd_req    = 1'b1;
        repeat (3) @(negedge clk);
        repeat (P_SPIN) @(negedge clk);
        checks++;
        if (step_out !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_step_hi step=%b, expected 1", step_out);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({step_out, dc_en, dc_dir, busy, handshake, fault} !== 7'b0 || steps_done !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs step=%b dc=%b dcdir=%b busy=%b hs=%b steps=%0d, expected all 0",
                     step_out, dc_en, dc_dir, busy, handshake, steps_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || dc_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_no_restart %0d busy cycles with held request, expected 0", bad);
        end
        cmd_req = 1'b0;
        repeat (4) @(negedge clk);
        cmd_amount = 2'b00;
        cmd_req    = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (dc_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_retoggle_early dc_en=%b, expected 0", dc_en);
        end
        @(negedge clk);
        checks++;
        if (dc_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_retoggle_start dc_en=%b busy=%b, expected 1 1", dc_en, busy);
        end
        drop_req();
        checks++;
        if (busy !== 1'b0 || dc_en !== 1'b0 || steps_done !== '0) begin
            errors++;
            $display("FAIL rstmid_abort_spinup busy=%b dc=%b steps=%0d, expected 0 0 0", busy, dc_en, steps_done);
        end
    endtask

    task automatic test_amount_change();
        int e_st, pulses, len;
        logic prev;
        e_st = 0; pulses = 0; prev = 1'b0;
        len = P_SPIN + 2*P_HALF*P_A2 + P_SETTLE + 2;
        cmd_amount = 2'b10;
        cmd_req    = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 9)  cmd_amount = 2'b01;
            if (i == 13) cmd_amount = 2'b11;
            if (step_out !== exp_step(i, P_A2)) e_st++;
            if (step_out === 1'b1 && prev === 1'b0) pulses++;
            prev = step_out;
        end
        checks++;
        if (e_st != 0 || pulses != P_A2) begin
            errors++;
            $display("FAIL amtchg_wave wrong_cycles=%0d pulses=%0d, expected 0 %0d", e_st, pulses, P_A2);
        end
        checks++;
        if (steps_done !== P_CNT_W'(P_A2) || handshake !== 1'b1) begin
            errors++;
            $display("FAIL amtchg_done steps=%0d hs=%b, expected %0d 1", steps_done, handshake, P_A2);
        end
        drop_req();
    endtask

    task automatic test_done_hold();
        int e_hs, e_ft, e_bz;
        e_hs = 0; e_ft = 0; e_bz = 0;
        test_dispense_run(2'b01, P_A1, "hold_run");
`ifdef DISPENSE_HS_TIMEOUT_EN
        begin
            int d;
            d = P_SPIN + 2*P_HALF*P_A1 + P_SETTLE;
            for (int i = d + 2; i <= d + 11; i++) begin
                @(negedge clk);
                if (fault !== (i == d + P_HS_TO)) e_ft++;
                if (handshake !== (i < d + P_HS_TO)) e_hs++;
                if (busy !== (i < d + P_HS_TO)) e_bz++;
            end
            checks++;
            if (e_ft != 0) begin
                errors++;
                $display("FAIL timeout_fault_pulse %0d wrong cycles, expected 0", e_ft);
            end
            checks++;
            if (e_hs != 0 || e_bz != 0) begin
                errors++;
                $display("FAIL timeout_hs_busy hs_err=%0d busy_err=%0d, expected 0 0", e_hs, e_bz);
            end
            e_bz = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (busy !== 1'b0 || dc_en !== 1'b0 || fault !== 1'b0) e_bz++;
            end
            checks++;
            if (e_bz != 0) begin
                errors++;
                $display("FAIL timeout_no_restart %0d bad cycles, expected 0", e_bz);
            end
        end
`else
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (handshake !== 1'b1) e_hs++;
            if (fault !== 1'b0) e_ft++;
            if (busy !== 1'b1) e_bz++;
        end
        checks++;
        if (e_hs != 0 || e_ft != 0 || e_bz != 0) begin
            errors++;
            $display("FAIL done_wait hs_err=%0d fault_err=%0d busy_err=%0d, expected 0 0 0", e_hs, e_ft, e_bz);
        end
`endif
        drop_req();
    endtask

    initial begin
        test_reset();
        test_dispense_run(2'b01, P_A1, "amt01");
        test_release();
        test_dispense_run(2'b00, P_A0, "amt00");
        drop_req();
        test_abort();
        test_reset_mid();
        test_amount_change();
        test_dispense_run(2'b11, P_A3, "zero_target");
        drop_req();
        test_done_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
